cha_bank_ctrl: RTL and testbench

CHA_BANK_CTRL -- requirements
Module: cha_bank_ctrl

---
 rtl/cha_bank_ctrl.sv | 145 ++++++++++++++
 tb/tb_cha_bank_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/cha_bank_ctrl.sv
// C/S-ROM address latching, C-ROM pair select and Z80 M-ROM banking.
// PCK1B/PCK2B/SDRD0 rising edges load latches and window registers on CLK_24M.
module cha_bank_ctrl #(
    parameter int PAIRS     = 4,
    parameter int BANK_BITS = 2,
    parameter int ZMC_EN    = 1
) (
    input  logic             CLK_24M,
    input  logic             RESET,
    input  logic [23:0]      PBUS,
    input  logic             PCK1B,
    input  logic             PCK2B,
    input  logic             CA4,
    input  logic             S2H1,
    input  logic [15:0]      SDA,
    input  logic             SDRD0,
    output logic [20:0]      C_ADDR,
    output logic [16:0]      S_ADDR,
    output logic [PAIRS-1:0] nPAIR_CE,
    output logic [10:0]      MA,
    output logic             BANK_ERR
);

    logic                 pck1_q;
    logic                 pck2_q;
    logic                 pck1_blk;
    logic                 pck2_blk;
    logic                 pck1_rise;
    logic                 pck2_rise;
    logic [19:0]          c_latch;
    logic [BANK_BITS-1:0] c_bank;
    logic [15:0]          s_latch;
    logic [PAIRS-1:0]     n_pair;
    logic                 bank_err;
    logic                 unused_bits;

    function automatic logic [PAIRS-1:0] pair_decode(input logic [BANK_BITS-1:0] bank);
        logic [PAIRS-1:0] sel;
        sel = '1;
        for (int i = 0; i < PAIRS; i++) begin
            if (int'(bank) == i) sel[i] = 1'b0;
        end
        return sel;
    endfunction

    function automatic logic bank_ok(input logic [BANK_BITS-1:0] bank);
        return int'(bank) < PAIRS;
    endfunction

    // The blk flags swallow a strobe that was already high when RESET dropped;
    // they clear once the strobe has been seen low.
    assign pck1_rise = PCK1B & ~pck1_q & ~pck1_blk;
    assign pck2_rise = PCK2B & ~pck2_q & ~pck2_blk;

    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            pck1_q   <= 1'b0;
            pck2_q   <= 1'b0;
            pck1_blk <= PCK1B;
            pck2_blk <= PCK2B;
        end else begin
            pck1_q   <= PCK1B;
            pck2_q   <= PCK2B;
            pck1_blk <= pck1_blk & PCK1B;
            pck2_blk <= pck2_blk & PCK2B;
        end
    end

    // Pair enables are decoded from the incoming bank so they land with C_BANK.
    always_ff @(posedge CLK_24M) begin
        if (RESET) begin
            c_latch  <= '0;
            c_bank   <= '0;
            n_pair   <= pair_decode('0);
            s_latch  <= '0;
            bank_err <= 1'b0;
        end else begin
            if (pck1_rise) begin
                c_latch <= PBUS[19:0];
                c_bank  <= PBUS[20 +: BANK_BITS];
                n_pair  <= pair_decode(PBUS[20 +: BANK_BITS]);
            end
            if (pck2_rise) s_latch <= PBUS[15:0];
            if (!bank_ok(c_bank)) bank_err <= 1'b1;
        end
    end

    assign C_ADDR   = {c_latch[19:4], CA4, c_latch[3:0]};
    assign S_ADDR   = {s_latch[15:3], S2H1, s_latch[2:0]};
    assign nPAIR_CE = n_pair;
    assign BANK_ERR = bank_err;

    generate
        if (ZMC_EN != 0) begin : g_zmc
            logic       sdrd_q;
            logic       sdrd_blk;
            logic       sdrd_rise;
            logic [7:0] w0;
            logic [7:0] w1;
            logic [7:0] w2;
            logic [7:0] w3;
            logic [10:0] ma_win;

            assign sdrd_rise = SDRD0 & ~sdrd_q & ~sdrd_blk;

            // Window defaults reproduce the identity map of SDA onto MA.
            always_ff @(posedge CLK_24M) begin
                if (RESET) begin
                    sdrd_q   <= 1'b0;
                    sdrd_blk <= SDRD0;
                    w0       <= 8'h1E;
                    w1       <= 8'h0E;
                    w2       <= 8'h06;
                    w3       <= 8'h02;
                end else begin
                    sdrd_q   <= SDRD0;
                    sdrd_blk <= sdrd_blk & SDRD0;
                    if (sdrd_rise) begin
                        case (SDA[1:0])
                            2'd0:    w0 <= SDA[15:8];
                            2'd1:    w1 <= SDA[15:8];
                            2'd2:    w2 <= SDA[15:8];
                            default: w3 <= SDA[15:8];
                        endcase
                    end
                end
            end

            always_comb begin
                ma_win = {6'b0, SDA[15:11]};
                if (SDA[15:11] == 5'b11110)     ma_win = {3'b0, w0};
                else if (SDA[15:12] == 4'b1110) ma_win = {2'b0, w1, SDA[11]};
                else if (SDA[15:13] == 3'b110)  ma_win = {1'b0, w2, SDA[12:11]};
                else if (SDA[15:14] == 2'b10)   ma_win = {w3, SDA[13:11]};
            end

            assign MA = ma_win;
        end else begin : g_nozmc
            assign MA = {6'b0, SDA[15:11]};
        end
    endgenerate

    assign unused_bits = ^{PBUS, SDA, SDRD0};

endmodule

// File: tb/tb_cha_bank_ctrl.sv
// Directed bench for cha_bank_ctrl: a default instance and a PAIRS=3, ZMC_EN=0
// instance share every input.
module tb_cha_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pbus;
    logic        pck1b;
    logic        pck2b;
    logic        ca4;
    logic        s2h1;
    logic [15:0] sda;
    logic        sdrd0;

    logic [20:0] c_addr_a;
    logic [16:0] s_addr_a;
    logic [3:0]  npair_a;
    logic [10:0] ma_a;
    logic        err_a;
    logic [20:0] c_addr_b;
    logic [16:0] s_addr_b;
    logic [2:0]  npair_b;
    logic [10:0] ma_b;
    logic        err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cha_bank_ctrl dut_a (
        .CLK_24M(clk), .RESET(rst), .PBUS(pbus), .PCK1B(pck1b), .PCK2B(pck2b),
        .CA4(ca4), .S2H1(s2h1), .SDA(sda), .SDRD0(sdrd0),
        .C_ADDR(c_addr_a), .S_ADDR(s_addr_a), .nPAIR_CE(npair_a), .MA(ma_a),
        .BANK_ERR(err_a)
    );

    cha_bank_ctrl #(.PAIRS(3), .BANK_BITS(2), .ZMC_EN(0)) dut_b (
        .CLK_24M(clk), .RESET(rst), .PBUS(pbus), .PCK1B(pck1b), .PCK2B(pck2b),
        .CA4(ca4), .S2H1(s2h1), .SDA(sda), .SDRD0(sdrd0),
        .C_ADDR(c_addr_b), .S_ADDR(s_addr_b), .nPAIR_CE(npair_b), .MA(ma_b),
        .BANK_ERR(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; pbus = '0; pck1b = 0; pck2b = 0; ca4 = 0; s2h1 = 0;
        sda = '0; sdrd0 = 0;
        tick(); tick(); tick();

        check("rst_c_addr", 32'(c_addr_a), 32'h0);
        check("rst_s_addr", 32'(s_addr_a), 32'h0);
        check("rst_npair_a", 32'(npair_a), 32'b1110);
        check("rst_npair_b", 32'(npair_b), 32'b110);
        check("rst_err_a", 32'(err_a), 32'h0);

        rst = 1'b0;
        tick();
        sda = 16'hF234; #1;
        check("ma_f234", 32'(ma_a), 32'h01E);
        sda = 16'h9000; #1;
        check("ma_9000", 32'(ma_a), 32'h012);
        sda = 16'hE800; #1;
        check("ma_e800", 32'(ma_a), 32'h01D);
        sda = 16'hD000; #1;
        check("ma_d000", 32'(ma_a), 32'h01A);

        // C latch with bank 2
        pbus = 24'h2ABCDE; ca4 = 1; pck1b = 1;
        tick();
        check("c_addr_ca4_1", 32'(c_addr_a), 32'h1579BE);
        check("npair_a_bank2", 32'(npair_a), 32'b1011);
        check("npair_b_bank2", 32'(npair_b), 32'b011);
        pck1b = 0;
        tick();
        check("err_a_bank2", 32'(err_a), 32'h0);
        check("err_b_bank2", 32'(err_b), 32'h0);
        ca4 = 0; #1;
        check("c_addr_ca4_0", 32'(c_addr_a), 32'h1579AE);

        // Window W3 write then lookup
        sda = 16'h0A03; sdrd0 = 1;
        tick();
        sdrd0 = 0; sda = 16'hA800; #1;
        check("ma_w3_zmc", 32'(ma_a), 32'h055);
        check("ma_w3_nozmc", 32'(ma_b), 32'h015);
        tick();
        sda = 16'hFF00; sdrd0 = 1;
        #1;
        sda = 16'hF000; #1;
        check("ma_w0_before", 32'(ma_a), 32'h01E);
        sda = 16'hFF00;
        tick();
        sdrd0 = 0; sda = 16'hF000; #1;
        check("ma_w0_ff", 32'(ma_a), 32'h0FF);
        check("ma_w0_nozmc", 32'(ma_b), 32'h01E);
        sda = 16'hF800; #1;
        check("ma_f800", 32'(ma_a), 32'h01F);

        // Out-of-range bank on the PAIRS=3 instance
        pbus = 24'h300000; pck1b = 1;
        tick();
        check("npair_b_bank3", 32'(npair_b), 32'b111);
        check("npair_a_bank3", 32'(npair_a), 32'b0111);
        check("err_b_same_edge", 32'(err_b), 32'h0);
        pck1b = 0;
        tick();
        check("err_b_set", 32'(err_b), 32'h1);
        check("err_a_clear", 32'(err_a), 32'h0);
        pbus = 24'h100000; pck1b = 1;
        tick();
        pck1b = 0;
        tick();
        check("npair_b_bank1", 32'(npair_b), 32'b101);
        check("err_b_sticky", 32'(err_b), 32'h1);

        // Simultaneous C and S latch
        pbus = 24'h001234; s2h1 = 0; ca4 = 0; pck1b = 1; pck2b = 1;
        tick();
        check("dual_c_addr", 32'(c_addr_a), 32'h02464);
        check("dual_s_addr", 32'(s_addr_a), 32'h02464);
        check("dual_npair_a", 32'(npair_a), 32'b1110);
        s2h1 = 1; #1;
        check("s_addr_s2h1", 32'(s_addr_a), 32'h0246C);

        // Reset with strobes held high
        rst = 1;
        tick(); tick();
        check("rst2_err_b", 32'(err_b), 32'h0);
        check("rst2_c_addr", 32'(c_addr_a), 32'h0);
        sda = 16'hF000; #1;
        check("rst2_ma_w0", 32'(ma_a), 32'h01E);
        pbus = 24'h0FFFFF; s2h1 = 0;
        rst = 0;
        tick(); tick(); tick();
        check("held_c_addr", 32'(c_addr_a), 32'h0);
        check("held_s_addr", 32'(s_addr_a), 32'h0);
        pck1b = 0;
        tick();
        pck1b = 1;
        tick();
        check("relatch_c_addr", 32'(c_addr_a), 32'h1FFFEF);
        check("relatch_s_addr", 32'(s_addr_a), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
